calc_core: RTL and testbench
============================

// Module: calc_core
// PURPOSE
//  Sequential arithmetic engine of the TinyTapeout calculator top. Accepts
//  operand A, operand B and an opcode as three successive valid/ready beats,
//  executes (single-cycle logic/add ops, W-cycle iterative MUL/DIV), then
//  presents the result with flags until the consumer accepts it. The top
//  drives the input beats from ui_in/uio_in and maps the result to uo_out.
// PARAMETERS
//  W   8   operand/result width in bits (W >= 2)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  ena        in   1  design enable; low freezes all state (no transitions)
//  in_valid   in   1  input beat valid
//  in_ready   out  1  input beat accepted when in_valid & in_ready
//  in_data    in   W  operand value, or opcode in bits [2:0] on the OP beat
//  out_valid  out  1  result available
//  out_ready  in   1  consumer accepts result when out_valid & out_ready
//  result     out  W  result value
//  ovf        out  1  carry (ADD), borrow (SUB), high half nonzero (MUL)
//  dz         out  1  divide/modulo by zero
//  busy       out  1  high in EXEC
// BEHAVIOUR
//  Reset (async, rst_n low): state=GET_A; in_ready=0 during reset, 1 from
//   first edge after release; out_valid=0, result=0, ovf=0, dz=0, busy=0;
//   operand regs, counter cleared. Reset mid-EXEC or mid-DONE aborts, no output.
//  States: GET_A -> GET_B -> GET_OP -> EXEC -> DONE -> GET_A.
//  - GET_A/GET_B/GET_OP: in_ready=1; on accepted beat latch in_data and advance.
//    No beat: hold. in_data[W-1:3] ignored on OP beat.
//  - EXEC: in_ready=0, busy=1. Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR,
//    4 XOR, 5 MUL (low W bits), 6 DIV (A/B unsigned), 7 MOD (A%B unsigned).
//    Ops 0-4: one EXEC cycle. Ops 5-7: exactly W EXEC cycles (shift-add
//    multiply; restoring divide, one quotient bit per cycle, MSB first).
//    Latency from accepted OP beat to out_valid: 2 cycles (ops 0-4),
//    W+1 cycles (ops 5-7).
//  - DIV/MOD with B=0: no iteration skipped shortcut allowed that changes
//    latency; result=all ones (DIV) or A (MOD), dz=1. dz=0 otherwise.
//  - ovf: ADD carry out; SUB borrow (A<B); MUL 2W product [2W-1:W] != 0;
//    0 for ops 2-4, 6, 7.
//  - DONE: out_valid=1, result/ovf/dz stable while out_valid & !out_ready.
//    On acceptance: out_valid=0 next cycle, state=GET_A, in_ready=1 next
//    cycle. in_valid while in DONE is not accepted (in_ready=0).
//  - result/ovf/dz keep last value after acceptance until next DONE.
//  - ena=0: every register holds, including EXEC counter; in_ready and
//    out_valid forced 0 so no handshake completes; resuming ena continues.
//  - All arithmetic unsigned, modulo 2^W; no unknowns propagate on outputs.
// TESTING
//  1. A=200,B=100,op=0 -> result=44, ovf=1, dz=0, out_valid 2 cycles after OP.
//  2. A=5,B=9,op=1 -> result=252, ovf=1; A=0xF0,B=0x3C,op=4 -> result=0xCC.
//  3. A=13,B=11,op=5 -> result=143, ovf=0 after 9 cycles; A=16,B=16 -> 0, ovf=1.
//  4. A=200,B=7,op=6 -> 28; op=7 -> 4; B=0 op=6 -> 255, dz=1, latency 9.
//  5. Hold out_ready=0 10 cycles in DONE -> result stable, in_ready=0; then
//     out_ready=1 -> next cycle GET_A, new A beat accepted.
//  6. Assert rst_n low at EXEC cycle 4 of MUL -> all outputs reset immediately;
//     ena=0 for 5 cycles mid-DIV -> latency extends by exactly 5, result correct.

Source files
------------

// File: rtl/calc_core.sv
// Sequential calculator engine: A, B, opcode beats in; one-cycle logic/add
// ops or W-cycle shift-add multiply / restoring divide; result held until taken.
module calc_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         dz,
    output logic         busy
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [2:0] S_A  = 3'd0;
    localparam logic [2:0] S_B  = 3'd1;
    localparam logic [2:0] S_OP = 3'd2;
    localparam logic [2:0] S_EX = 3'd3;
    localparam logic [2:0] S_DN = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_MOD = 3'd7;

    logic [2:0]    state;
    logic          live;
    logic [W-1:0]  a, b;
    logic [2:0]    op;
    logic [W-1:0]  hi, lo;
    logic [CW-1:0] cnt;

    logic         in_fire, out_fire, iter;
    logic [W:0]   sum, diff;
    logic [W-1:0] alu_res;
    logic         alu_ovf;
    logic [W:0]   mul_sum, div_r, div_d;
    logic         div_ge;
    logic [W-1:0] nhi, nlo;

    // in_ready stays low until the first edge after reset release
    assign in_ready  = live & ena &
                       (state == S_A || state == S_B || state == S_OP);
    assign out_valid = ena & (state == S_DN);
    assign busy      = (state == S_EX);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign iter      = (op >= OP_MUL);

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = sum[W-1:0];
                alu_ovf = sum[W];
            end
            OP_SUB: begin
                alu_res = diff[W-1:0];
                alu_ovf = diff[W];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // MUL: {hi,lo} is the product register with the multiplier in lo.
    // DIV/MOD: hi is the partial remainder, lo shifts dividend out/quotient in.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    assign div_r   = {hi, lo[W-1]};
    assign div_ge  = (div_r >= {1'b0, b});
    assign div_d   = div_r - {1'b0, b};

    always_comb begin
        if (op == OP_MUL) begin
            nhi = mul_sum[W:1];
            nlo = {mul_sum[0], lo[W-1:1]};
        end else begin
            nhi = div_ge ? div_d[W-1:0] : div_r[W-1:0];
            nlo = {lo[W-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_A;
            live   <= 1'b0;
            a      <= '0;
            b      <= '0;
            op     <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
        end else if (ena) begin
            live <= 1'b1;
            case (state)
                S_A: if (in_fire) begin
                    a     <= in_data;
                    state <= S_B;
                end
                S_B: if (in_fire) begin
                    b     <= in_data;
                    state <= S_OP;
                end
                S_OP: if (in_fire) begin
                    op    <= in_data[2:0];
                    cnt   <= '0;
                    hi    <= '0;
                    lo    <= (in_data[2:0] == OP_MUL) ? b : a;
                    state <= S_EX;
                end
                S_EX: if (!iter) begin
                    result <= alu_res;
                    ovf    <= alu_ovf;
                    dz     <= 1'b0;
                    state  <= S_DN;
                end else begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        result <= (op == OP_MOD) ? nhi : nlo;
                        ovf    <= (op == OP_MUL) && (nhi != '0);
                        dz     <= (op != OP_MUL) && (b == '0);
                        state  <= S_DN;
                    end
                end
                S_DN: if (out_fire) state <= S_A;
                default: state <= S_A;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_core.sv
// Directed and randomized checks of calc_core against an arithmetic model.
// Covers latency, flags, DONE hold, enable freeze and reset abort.
module tb_calc_core;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         ovf;
    logic         dz;
    logic         busy;

    int checks = 0;
    int errors = 0;

    calc_core #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .dz(dz), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the spec rules
    function automatic void model(input int a, input int b, input int op,
                                  output int res, output int v,
                                  output int z);
        int m;
        m = 1 << W;
        v = 0;
        z = 0;
        case (op)
            0: begin res = (a + b) % m; v = (a + b >= m); end
            1: begin res = (a - b + m) % m; v = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * b) % m; v = (a * b >= m); end
            6: begin res = (b == 0) ? m - 1 : a / b; z = (b == 0); end
            default: begin res = (b == 0) ? a : a % b; z = (b == 0); end
        endcase
    endfunction

    task automatic beat(input int d);
        int t;
        t = 0;
        in_data  = W'(d);
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("beat_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns cycles from the OP-accepting edge (counted as 1) to out_valid
    task automatic run_op(input int a, input int b, input int op,
                          input int pause_at, output int lat);
        beat(a);
        beat(b);
        beat(op);
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (pause_at != 0 && lat == pause_at) begin
                ena = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                chk("frozen_handshake", 32'({out_valid, in_ready}), 0);
                chk("frozen_busy", 32'(busy), 1);
                ena = 1'b1;
                lat += 5;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic accept(input int exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("acc_out_valid", 32'(out_valid), 0);
        chk("acc_in_ready", 32'(in_ready), 1);
        chk("acc_result_kept", 32'(result), exp_res);
    endtask

    task automatic check_op(input int a, input int b, input int op,
                            input int pause_at);
        int er, ev, ez, lat, el;
        model(a, b, op, er, ev, ez);
        el = (op >= 5) ? W + 1 : 2;
        if (pause_at != 0) el += 5;
        run_op(a, b, op, pause_at, lat);
        chk($sformatf("lat op%0d", op), lat, el);
        chk($sformatf("res %0d op%0d %0d", a, op, b), 32'(result), er);
        chk($sformatf("ovf %0d op%0d %0d", a, op, b), 32'(ovf), ev);
        chk($sformatf("dz %0d op%0d %0d", a, op, b), 32'(dz), ez);
        chk("done_busy", 32'(busy), 0);
        accept(er);
    endtask

    initial begin
        int a, b, op, lat;

        #2;
        chk("rst_outs", 32'({in_ready, out_valid, ovf, dz, busy}), 0);
        chk("rst_result", 32'(result), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("rel_in_ready_high", 32'(in_ready), 1);

        check_op(200, 100, 0, 0);
        check_op(5, 9, 1, 0);
        check_op(8'hF0, 8'h3C, 4, 0);
        check_op(8'hF0, 8'h3C, 2, 0);
        check_op(8'hF0, 8'h3C, 3, 0);
        check_op(13, 11, 5, 0);
        check_op(16, 16, 5, 0);
        check_op(200, 7, 6, 0);
        check_op(200, 7, 7, 0);
        check_op(200, 0, 6, 0);
        check_op(200, 0, 7, 0);
        check_op(255, 1, 0, 0);
        check_op(255, 255, 5, 0);

        // DONE hold with an ignored input beat
        run_op(77, 3, 5, 0, lat);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0 || i == 9) begin
                chk("hold_result", 32'(result), 231);
                chk("hold_in_ready", 32'(in_ready), 0);
                chk("hold_out_valid", 32'(out_valid), 1);
            end
        end
        in_valid = 1'b0;
        accept(231);
        check_op(100, 3, 0, 0);

        // ena freeze in the middle of a divide
        check_op(200, 7, 6, 3);
        check_op(123, 0, 7, 4);

        // Reset during EXEC cycle 4 of a multiply
        beat(13);
        beat(11);
        beat(5);
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 32'({in_ready, out_valid, ovf, dz, busy}), 0);
        chk("abort_result", 32'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready_low", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("abort_in_ready_high", 32'(in_ready), 1);
        chk("abort_no_output", 32'(out_valid), 0);
        check_op(13, 11, 5, 0);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            op = $urandom_range(0, 7);
            check_op(a, b, op,
                     (op >= 5 && $urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
